if_stage: RTL and testbench

Instruction-fetch stage: the initiator on the instruction-memory read interface. Holds the program counter, drives a byte address to the combinational word-indexed instruction memory, and captures the returned word into the IF/ID pipeline register. Handles sequential fetch, taken-branch redirect, hazard freeze and pipeline flush, and keeps a fetched-instruction count. Sits between the instruction memory and the ID stage.

---
 rtl/if_stage.sv | 84 ++++++++
 tb/tb_if_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address drive and IF/ID pipeline register.
// Optional IF_BOUND_CHECK_EN: stop fetching past MEM_DEPTH words until a branch brings the PC back in range.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_DEPTH = 32,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        flush,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic [15:0] fetch_count
);

    // Memory interface has no handshake: imem_data is valid for imem_addr in the same
    // cycle, and IF/ID loads every edge unless rst, flush or freeze says otherwise.

`ifdef IF_BOUND_CHECK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif
    localparam logic [31:0] PC_LIMIT = 32'(MEM_DEPTH * 4);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        out_of_bound;
    logic        load_valid;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // A pending branch overrides the bound check so the redirect can bring fetch back in range.
    assign out_of_bound = BOUND_EN && (pc >= PC_LIMIT) && !branch_taken;
    assign load_valid   = !flush && !freeze && !out_of_bound;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= {RESET_PC[31:2], 2'b00};
        end else if (branch_taken) begin
            pc <= {branch_addr[31:2], 2'b00};
        end else if (freeze || out_of_bound) begin
            pc <= pc;
        end else begin
            pc <= pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr_out <= NOP_INSTR;
            pc_out    <= 32'd0;
            valid_out <= 1'b0;
        end else if (freeze) begin
            instr_out <= instr_out;
            pc_out    <= pc_out;
            valid_out <= valid_out;
        end else if (out_of_bound) begin
            instr_out <= NOP_INSTR;
            pc_out    <= pc_plus4;
            valid_out <= 1'b0;
        end else begin
            instr_out <= imem_data;
            pc_out    <= pc_plus4;
            valid_out <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 16'd0;
        end else if (load_valid && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: free fetch, freeze, redirect, reset override, count saturation, range bound.
// Memory model returns 32'h1000_0000 + word index for any address.
module tb_if_stage;

    localparam logic [31:0] NOP  = 32'hE1A0_0000;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        flush;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .MEM_DEPTH(8),
        .NOP_INSTR(NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .flush       (flush),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .valid_out   (valid_out),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_data = BASE + {2'b00, imem_addr[31:2]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic r, input logic fz, input logic bt,
                         input logic [31:0] ba, input logic fl);
        rst = r; freeze = fz; branch_taken = bt; branch_addr = ba; flush = fl;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc4,
                              input logic v, input logic [15:0] cnt);
        check({tag, ".instr"}, instr_out, ins);
        check({tag, ".pc_out"}, pc_out, pc4);
        check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
        check({tag, ".count"}, {16'd0, fetch_count}, {16'd0, cnt});
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(2);
        check_ifid("reset", NOP, 32'd0, 1'b0, 16'd0);
        check("reset.addr", imem_addr, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Sequential fetch: two edges, instructions arrive one edge after their address.
        exp_q.push_back(BASE + 32'd0);
        exp_q.push_back(BASE + 32'd1);
        for (int i = 1; i <= 2; i++) begin
            step(1);
            check("seq.addr", imem_addr, 32'(4 * i));
            check("seq.instr", instr_out, exp_q.pop_front());
            check("seq.pc_out", pc_out, 32'(4 * i));
        end
        check("seq.count", {16'd0, fetch_count}, 32'd2);

        // Freeze for three cycles at PC=8.
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("frz.addr", imem_addr, 32'd8);
            check_ifid("frz", BASE + 32'd1, 32'd8, 1'b1, 16'd2);
        end
        freeze = 1'b0;
        step(1);
        check("rel.addr", imem_addr, 32'd12);
        check_ifid("rel", BASE + 32'd2, 32'd12, 1'b1, 16'd3);

        // Branch with flush; target low bits discarded.
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0017, 1'b1);
        step(1);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        check("br.addr", imem_addr, 32'h14);
        check_ifid("br", NOP, 32'd0, 1'b0, 16'd3);
        step(1);
        check("br2.addr", imem_addr, 32'h18);
        check_ifid("br2", BASE + 32'd5, 32'd24, 1'b1, 16'd4);

        // Get to PC=20, then reset while frozen.
        drive(1'b0, 1'b0, 1'b1, 32'd20, 1'b1);
        step(1);
        check("pre_rst.addr", imem_addr, 32'd20);
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1);
        check("rst_frz.addr", imem_addr, 32'd0);
        check_ifid("rst_frz", NOP, 32'd0, 1'b0, 16'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Branch while frozen: PC redirects, IF/ID holds.
        step(1);
        check_ifid("pre_bf", BASE + 32'd0, 32'd4, 1'b1, 16'd1);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_000D, 1'b0);
        step(1);
        check("bf.addr", imem_addr, 32'h0C);
        check_ifid("bf", BASE + 32'd0, 32'd4, 1'b1, 16'd1);

        // Saturation: permanent branch to 0, every edge loads a valid word.
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1);
        drive(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
        step(65534);
        check("sat.pre", {16'd0, fetch_count}, 32'h0000_FFFE);
        step(1);
        check("sat.hit", {16'd0, fetch_count}, 32'h0000_FFFF);
        step(3);
        check_ifid("sat.hold", BASE + 32'd0, 32'd4, 1'b1, 16'hFFFF);

        // Range bound at MEM_DEPTH=8 words (byte limit 32).
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(8);
        check("bnd.addr", imem_addr, 32'd32);
        check_ifid("bnd.last", BASE + 32'd7, 32'd32, 1'b1, 16'd8);
        step(2);
`ifdef IF_BOUND_CHECK_EN
        check("bnd.addr_hold", imem_addr, 32'd32);
        check_ifid("bnd.out", NOP, 32'd36, 1'b0, 16'd8);
`else
        check("bnd.addr_free", imem_addr, 32'd40);
        check_ifid("bnd.free", BASE + 32'd9, 32'd40, 1'b1, 16'd10);
`endif
        drive(1'b0, 1'b0, 1'b1, 32'd0, 1'b1);
        step(1);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        check("bnd.redir", imem_addr, 32'd0);
        check({"bnd.redir", ".valid"}, {31'd0, valid_out}, 32'd0);
        step(1);
        check("bnd.resume.instr", instr_out, BASE + 32'd0);
        check("bnd.resume.pc_out", pc_out, 32'd4);
        check("bnd.resume.valid", {31'd0, valid_out}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
